// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the receive-state encoding exported on uart_rx_ctrl.state and the
// default frame/baud constants used as parameter defaults by the receiver.
package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 434;  // 50 MHz / 115200

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    START = 3'b001,
    DATA  = 3'b010,
    STOP  = 3'b011,
    DONE  = 3'b100
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-period timer for the UART receiver.
// Ports:
//   clk, rst   - system clock, asynchronous active-high reset
//   clear      - restart the count from zero on the next edge
//   half_tick  - count has reached the mid-point of a bit ((CLKS_PER_BIT-1)/2)
//   full_tick  - count has reached the last cycle of a bit (CLKS_PER_BIT-1)
module uart_rx_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic half_tick,
  output logic full_tick
);

  localparam int              CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] clk_cnt;

  // Holds at FULL rather than wrapping; the controller always clears or
  // leaves the state on full_tick, so wrapping would never be wanted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_cnt <= '0;
    end else if (clear) begin
      clk_cnt <= '0;
    end else if (clk_cnt != FULL) begin
      clk_cnt <= clk_cnt + 1'b1;
    end
  end

  assign half_tick = (clk_cnt == HALF);
  assign full_tick = (clk_cnt == FULL);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receive controller.
// Synchronizes rx_in, detects the start bit, samples each bit at mid-period,
// assembles the byte LSB-first and checks the stop bit.
// Ports:
//   clk, rst    - system clock, asynchronous active-high reset
//   rx_in       - raw serial line, idle high, asynchronous to clk
//   data_out    - last correctly received byte (held until the next good frame)
//   data_valid  - one-cycle pulse when data_out updates
//   frame_err   - one-cycle pulse when a stop bit samples low
//   busy        - high whenever the receiver is not IDLE
//   state       - current receive state encoding
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic [2:0]           state
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  uart_rx_state_t       state_q, state_next;
  logic                 rx_meta, rx_s;
  logic                 armed;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 half_tick, full_tick, cnt_clear;
  logic                 take_bit, good_stop, bad_stop;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  // The counter restarts on every state change, after each data bit, and is
  // held at zero while idle.
  assign cnt_clear = (state_next != state_q) || take_bit || (state_q == IDLE);

  uart_rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .half_tick(half_tick),
    .full_tick(full_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next = state_q;
    take_bit   = 1'b0;
    good_stop  = 1'b0;
    bad_stop   = 1'b0;
    case (state_q)
      IDLE:  if (!rx_s && armed) state_next = START;
      // A start bit that is high again at mid-bit was a glitch.
      START: if (half_tick) state_next = rx_s ? IDLE : DATA;
      DATA: begin
        if (full_tick) begin
          take_bit = 1'b1;
          if (bit_idx == LAST_BIT) state_next = STOP;
        end
      end
      STOP: begin
        if (full_tick) begin
          if (rx_s) begin
            state_next = DONE;
            good_stop  = 1'b1;
          end else begin
            state_next = IDLE;
            bad_stop   = 1'b1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx <= '0;
    end else if (state_next != state_q) begin
      bit_idx <= '0;
    end else if (take_bit) begin
      bit_idx <= bit_idx + 1'b1;
    end
  end

  // Byte assembly; contents are don't-care until a full frame has been taken.
  always_ff @(posedge clk) begin
    if (take_bit) shreg[bit_idx] <= rx_s;
  end

  // A framing error disarms the receiver until the line has been seen high,
  // so a held-low break line cannot be read as a stream of 0x00 frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed      <= 1'b1;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (bad_stop)  armed <= 1'b0;
      else if (rx_s) armed <= 1'b1;
      if (good_stop) data_out <= shreg;
      data_valid <= good_stop;
      frame_err  <= bad_stop;
      busy       <= (state_next != IDLE);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl with CLKS_PER_BIT = 8.
// Frames are driven as whole bit periods; a behavioural model records which
// bytes must appear and how many framing errors must be flagged.
module tb_uart_rx_ctrl;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;
  logic [2:0] state;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int fe_cnt     = 0;
  int fe_exp     = 0;
  int both_cnt   = 0;

  logic [7:0] got_q[$];
  int         got_t[$];
  logic [7:0] exp_q[$];

  uart_rx_ctrl #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy),
    .state     (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid) begin
      got_q.push_back(data_out);
      got_t.push_back(cyc);
    end
    if (frame_err) fe_cnt++;
    if (data_valid && frame_err) both_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    vectors++;
    assert (obs >= lo && obs <= hi) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Model: a frame with a high stop bit yields its byte, a low stop bit
  // yields one framing error and no byte.
  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (stop) exp_q.push_back(b);
    else      fe_exp++;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_in = f[i];
      repeat (CPB) tick();
    end
  endtask

  task automatic drain(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      chk({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
      void'(got_t.pop_front());
    end
    got_q.delete();
    got_t.delete();
    exp_q.delete();
  endtask

  initial begin
    int         c0;
    int         lat;
    int         gap;
    logic [7:0] b;
    logic       ok;

    rst   = 1'b1;
    rx_in = 1'b1;
    repeat (3) tick();
    chk("rst_state", state, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    rst = 1'b0;
    repeat (4) tick();

    // Single good frame and its latency
    c0 = cyc;
    send_frame(8'hA5, 1'b1);
    model_frame(8'hA5, 1'b1);
    repeat (3) tick();
    lat = (got_t.size() >= 1) ? got_t[0] - c0 : -1;
    chk_rng("a5_latency", lat, 79, 81);
    chk("a5_data_out", data_out, 8'hA5);
    drain("a5");
    chk("a5_ferr", fe_cnt, fe_exp);

    // Back-to-back frames, no idle bits between them
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    model_frame(8'h00, 1'b1);
    model_frame(8'hFF, 1'b1);
    repeat (3) tick();
    lat = (got_t.size() >= 2) ? got_t[1] - got_t[0] : -1;
    chk("b2b_spacing", lat, 80);
    drain("b2b");
    chk("b2b_ferr", fe_cnt, fe_exp);

    // Two-cycle glitch on an idle line
    rx_in = 1'b0;
    repeat (2) tick();
    rx_in = 1'b1;
    repeat (2) tick();
    chk("glitch_in_start", state, 3'd1);
    repeat (3) tick();
    chk("glitch_back_idle", state, 3'd0);
    repeat (20) tick();
    drain("glitch");
    chk("glitch_ferr", fe_cnt, fe_exp);

    // Framing error followed by a held-low break
    send_frame(8'h3C, 1'b0);
    model_frame(8'h3C, 1'b0);
    repeat (40) tick();
    chk("break_ferr", fe_cnt, fe_exp);
    chk("break_keep_data", data_out, 8'hFF);
    chk("break_state", state, 3'd0);
    chk("break_busy", busy, 1'b0);
    drain("break");
    rx_in = 1'b1;
    repeat (8) tick();
    send_frame(8'h5A, 1'b1);
    model_frame(8'h5A, 1'b1);
    repeat (3) tick();
    chk("after_break_data", data_out, 8'h5A);
    drain("after_break");
    chk("after_break_ferr", fe_cnt, fe_exp);

    // Reset asserted during bit 4 of 0x81
    b = 8'h81;
    rx_in = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 4; i++) begin
      rx_in = b[i];
      repeat (CPB) tick();
    end
    rx_in = b[4];
    repeat (3) tick();
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_state", state, 3'd0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_data", data_out, 8'h00);
    rx_in = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    repeat (4) tick();
    drain("midrst");
    chk("midrst_ferr", fe_cnt, fe_exp);
    send_frame(8'h81, 1'b1);
    model_frame(8'h81, 1'b1);
    repeat (3) tick();
    drain("post_rst");

    // Randomized frames with random gaps and occasional stop-bit errors
    for (int n = 0; n < 12; n++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      send_frame(b, ok);
      model_frame(b, ok);
      gap = ok ? int'($urandom_range(0, 10)) : int'($urandom_range(8, 16));
      rx_in = 1'b1;
      repeat (gap) tick();
    end
    repeat (10) tick();
    drain("rand");
    chk("rand_ferr", fe_cnt, fe_exp);
    chk("pulse_exclusive", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
